// File: rtl/lfsr_descrambler_rx.sv
// lfsr_descrambler_rx: receive-side descrambler for the 73-bit primary
// scrambler LFSR. Hunts for an unscrambled sync word, then XORs FRAME_LEN
// payload words with a 16-bit keystream slice, advancing 16 steps per word.
module lfsr_descrambler_rx #(
   parameter int unsigned POLY_WIDTH = 73,
   parameter int unsigned FRAME_LEN  = 256,
   parameter logic [15:0] SYNC_WORD  = 16'hF628
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write,
   input  logic [11:0]           addr,
   input  logic [31:0]           wdata,
   input  logic                  rx_valid,
   input  logic [15:0]           rx_data,
   output logic                  out_valid,
   output logic [15:0]           out_data,
   output logic                  out_sof,
   output logic                  out_eof,
   output logic                  locked,
   output logic [POLY_WIDTH-1:0] seed_dout
);

   localparam logic [11:0] ADDR_SEED_LO  = 12'h0DA;
   localparam logic [11:0] ADDR_SEED_MID = 12'h0DB;
   localparam logic [11:0] ADDR_SEED_HI  = 12'h0DC;
   localparam logic [15:0] LAST_IDX      = 16'(FRAME_LEN - 1);

   typedef enum logic {
      HUNT,
      RUN
   } state_t;

   state_t                  state, state_nx;
   logic [POLY_WIDTH-1:0]   seed;
   logic [POLY_WIDTH-1:0]   lfsr, lfsr_nx;
   logic [15:0]             cnt, cnt_nx;
   logic                    ov_nx, sof_nx, eof_nx, locked_nx;
   logic [15:0]             od_nx;
   logic                    sync_hit;
   logic                    last_word;

   // Single LFSR step: bit 72 is fed back into taps 0, 11, 50 and 58.
   function automatic logic [72:0] lfsr_step(input logic [72:0] s);
      logic [72:0] n;
      n     = {s[71:0], s[72]};
      n[11] = s[10] ^ s[72];
      n[50] = s[49] ^ s[72];
      n[58] = s[57] ^ s[72];
      return n;
   endfunction

   // One word advance: 16 chained steps, unrolled into a single cycle.
   function automatic logic [72:0] lfsr_adv16(input logic [72:0] s);
      logic [72:0] v;
      v = s;
      for (int unsigned i = 0; i < 16; i++) begin
         v = lfsr_step(v);
      end
      return v;
   endfunction

   assign seed_dout = seed;
   assign sync_hit  = rx_valid && (rx_data == SYNC_WORD);
   assign last_word = (cnt == LAST_IDX);

   // Seed shadow register: software writes only ever touch this copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed <= '0;
      end else if (write) begin
         case (addr)
            ADDR_SEED_LO:  seed[31:0]  <= wdata;
            ADDR_SEED_MID: seed[63:32] <= wdata;
            ADDR_SEED_HI:  seed[72:64] <= wdata[8:0];
            default:       ;
         endcase
      end
   end

   // Next-state, datapath and output decode for the hunt/run machine.
   always_comb begin
      state_nx = state;
      lfsr_nx  = lfsr;
      cnt_nx   = cnt;
      ov_nx    = 1'b0;
      od_nx    = out_data;
      sof_nx   = 1'b0;
      eof_nx   = 1'b0;
      unique case (state)
         HUNT: begin
            // Keep tracking the shadow so the frame starts from the value
            // present on the sync-detect cycle (a same-cycle write is not yet visible).
            lfsr_nx = seed;
            if (sync_hit) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end
         end
         RUN: begin
            if (rx_valid) begin
               od_nx   = rx_data ^ lfsr[72:57];
               ov_nx   = 1'b1;
               sof_nx  = (cnt == 16'd0);
               eof_nx  = last_word;
               lfsr_nx = lfsr_adv16(lfsr);
               cnt_nx  = cnt + 16'd1;
               if (last_word) begin
                  state_nx = HUNT;
                  lfsr_nx  = seed;
               end
            end
         end
         default: state_nx = HUNT;
      endcase
      locked_nx = (state_nx == RUN);
   end

   // State, LFSR, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         lfsr      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nx;
         lfsr      <= lfsr_nx;
         cnt       <= cnt_nx;
         out_valid <= ov_nx;
         out_data  <= od_nx;
         out_sof   <= sof_nx;
         out_eof   <= eof_nx;
         locked    <= locked_nx;
      end
   end

endmodule

// File: tb/tb_lfsr_descrambler_rx.sv
// tb_lfsr_descrambler_rx: directed sequence with randomized seeds, payloads
// and bubbles, checked cycle by cycle against a Galois-mask reference model.
module tb_lfsr_descrambler_rx;

   localparam int          FL   = 8;
   localparam logic [15:0] SYNC = 16'hF628;
   localparam logic [72:0] TAPS = (73'd1 << 0) | (73'd1 << 11) | (73'd1 << 50) | (73'd1 << 58);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic        rx_valid;
   logic [15:0] rx_data;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sof;
   logic        out_eof;
   logic        locked;
   logic [72:0] seed_dout;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic        m_run  = 1'b0;
   int          m_idx  = 0;
   logic [72:0] m_lfsr = '0;
   logic [72:0] m_seed = '0;
   logic [15:0] m_data = '0;
   int          eof_seen = 0;
   logic [15:0] pl_q[$];
   logic [72:0] sw_seed;

   lfsr_descrambler_rx #(
      .POLY_WIDTH(73),
      .FRAME_LEN (FL),
      .SYNC_WORD (SYNC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .write     (write),
      .addr      (addr),
      .wdata     (wdata),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .locked    (locked),
      .seed_dout (seed_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [72:0] mstep(input logic [72:0] s);
      return {s[71:0], 1'b0} ^ (s[72] ? TAPS : 73'd0);
   endfunction

   function automatic logic [72:0] madv(input logic [72:0] s);
      logic [72:0] v = s;
      for (int i = 0; i < 16; i++) v = mstep(v);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic v, input logic [15:0] d, input logic w,
                       input logic [11:0] a, input logic [31:0] wd);
      logic ev, es, ee;
      logic [15:0] ed;
      rx_valid = v; rx_data = d; write = w; addr = a; wdata = wd;
      @(posedge clk);
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = m_data;
      if (!m_run) begin
         if (v && d == SYNC) begin
            m_run = 1'b1; m_idx = 0; m_lfsr = m_seed;
         end
      end else if (v) begin
         ed = d ^ m_lfsr[72:57];
         ev = 1'b1;
         es = (m_idx == 0);
         ee = (m_idx == FL - 1);
         m_lfsr = madv(m_lfsr);
         m_idx++;
         if (ee) m_run = 1'b0;
      end
      m_data = ed;
      if (w) begin
         case (a)
            12'h0DA: m_seed[31:0]  = wd;
            12'h0DB: m_seed[63:32] = wd;
            12'h0DC: m_seed[72:64] = wd[8:0];
            default: ;
         endcase
      end
      #1;
      chk("out_valid", out_valid, ev);
      chk("locked", locked, m_run);
      chk("seed_dout", seed_dout, m_seed);
      if (ev) begin
         chk("out_data", out_data, ed);
         chk("out_sof", out_sof, es);
         chk("out_eof", out_eof, ee);
         if (pl_q.size() > 0) chk("payload", out_data, pl_q.pop_front());
         if (out_eof) eof_seen++;
      end else begin
         chk("out_data_hold", out_data, ed);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic wr_seed(input logic [72:0] s);
      tick(1'b0, 16'h0, 1'b1, 12'h0DA, s[31:0]);
      tick(1'b0, 16'h0, 1'b1, 12'h0DB, s[63:32]);
      tick(1'b0, 16'h0, 1'b1, 12'h0DC, {23'h0, s[72:64]});
   endtask

   // TX side: scrambles random payload from tx_seed; optional raw SYNC at
   // sync_idx, seed-mid write at wr_idx, early stop at stop_idx.
   task automatic send_frame(input logic [72:0] tx_seed, input int sync_idx,
                             input int wr_idx, input logic [31:0] wr_d, input int stop_idx);
      logic [72:0] tl;
      logic [15:0] pay, ks, rxw;
      int eof0;
      tl = tx_seed;
      eof0 = eof_seen;
      tick(1'b1, SYNC, 1'b0, 12'h0, 32'h0);
      for (int i = 0; i < FL; i++) begin
         if (i == stop_idx) return;
         repeat ($urandom_range(0, 2)) tick(1'b0, 16'($urandom), 1'b0, 12'h0, 32'h0);
         pay = 16'($urandom);
         ks  = tl[72:57];
         tl  = madv(tl);
         if (i == sync_idx) begin
            rxw = SYNC;
            pay = SYNC ^ ks;
         end else begin
            rxw = pay ^ ks;
         end
         pl_q.push_back(pay);
         if (i == wr_idx) tick(1'b1, rxw, 1'b1, 12'h0DB, wr_d);
         else             tick(1'b1, rxw, 1'b0, 12'h0, 32'h0);
      end
      chk("frame_eof_count", 73'(eof_seen - eof0), 73'd1);
   endtask

   initial begin
      logic [15:0] g;
      logic [31:0] nd;
      rst_n = 1'b0; write = 1'b0; addr = '0; wdata = '0; rx_valid = 1'b0; rx_data = '0;

      // 1: reset and idle
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_out_data", out_data, 16'h0);
      chk("rst_seed", seed_dout, 73'h0);
      rst_n = 1'b1;
      idle(3);

      // 2: seed = 1, zero payload -> keystream directly
      wr_seed(73'h1);
      tick(1'b1, SYNC, 1'b0, 12'h0, 32'h0);
      tick(1'b1, 16'h0, 1'b0, 12'h0, 32'h0);
      chk("t2_first_word", out_data, 16'h0);
      chk("t2_first_sof", out_sof, 1'b1);
      chk("t2_locked", locked, 1'b1);
      for (int i = 1; i < FL; i++) tick(1'b1, 16'h0, 1'b0, 12'h0, 32'h0);
      idle(2);

      // 3: random seed, two back-to-back frames with bubbles
      sw_seed = {9'($urandom), 32'($urandom), 32'($urandom)};
      wr_seed(sw_seed);
      send_frame(sw_seed, -1, -1, 32'h0, -1);
      send_frame(sw_seed, -1, -1, 32'h0, -1);
      idle(1);

      // 4: non-sync words in HUNT, then SYNC as payload in RUN
      for (int i = 0; i < 5; i++) begin
         g = 16'($urandom);
         if (g == SYNC) g = g ^ 16'h1;
         tick(1'b1, g, 1'b0, 12'h0, 32'h0);
      end
      send_frame(sw_seed, 2, -1, 32'h0, -1);

      // 5: seed write during word 3; next frame uses the new seed
      nd = $urandom;
      send_frame(sw_seed, -1, 3, nd, -1);
      sw_seed[63:32] = nd;
      idle(2);
      send_frame(sw_seed, -1, -1, 32'h0, -1);

      // 6: reset at word 5, reprogram, fresh frame
      send_frame(sw_seed, -1, -1, 32'h0, 5);
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_data", out_data, 16'h0);
      chk("midrst_locked", locked, 1'b0);
      chk("midrst_seed", seed_dout, 73'h0);
      m_run = 1'b0; m_seed = '0; m_data = '0; m_lfsr = '0;
      pl_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      sw_seed = {9'($urandom), 32'($urandom), 32'($urandom)};
      wr_seed(sw_seed);
      send_frame(sw_seed, -1, -1, 32'h0, -1);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
